// File: rtl/maze_solver_ctrl_if.sv
// maze_solver_ctrl_if: control, maze-memory and direction-stack signals of the maze solver.
interface maze_solver_ctrl_if;
  logic       start;
  logic       run;
  logic [7:0] mem_addr;
  logic       mem_wr;
  logic       mem_rd_data;
  logic       stk_push;
  logic [1:0] stk_dir;
  logic       stk_pop;
  logic [1:0] stk_top;
  logic       stk_empty;
  logic [3:0] cur_row;
  logic [3:0] cur_col;
  logic       move;
  logic       done;
  logic       fail;
  modport master (
    input  start, run, mem_rd_data, stk_top, stk_empty,
    output mem_addr, mem_wr, stk_push, stk_dir, stk_pop, cur_row, cur_col, move, done, fail
  );
  modport slave (
    output start, run, mem_rd_data, stk_top, stk_empty,
    input  mem_addr, mem_wr, stk_push, stk_dir, stk_pop, cur_row, cur_col, move, done, fail
  );
endinterface

// File: rtl/maze_solver_ctrl.sv
// maze_solver_ctrl: depth-first maze walker from (0,0) to (15,15) using external visited memory and direction stack.
module maze_solver_ctrl (
  input logic                 clk,
  input logic                 rst,
  maze_solver_ctrl_if.master  bus
);
  typedef enum logic [3:0] {IDLE, INIT, PROBE, WAIT, ADV, NEXTDIR, BACK, DONE, FAIL} state_t;
  state_t     state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d, nr, nc, br, bc;
  logic [1:0] dir_q, dir_d;
  logic [7:0] addr_q, addr_d;
  logic       act, oob, goal;
  always_comb begin
    act  = bus.run & ~rst;
    nr   = dir_q == 2'd1 ? row_q + 4'd1 : dir_q == 2'd3 ? row_q - 4'd1 : row_q;
    nc   = dir_q == 2'd0 ? col_q + 4'd1 : dir_q == 2'd2 ? col_q - 4'd1 : col_q;
    oob  = dir_q == 2'd0 ? &col_q : dir_q == 2'd1 ? &row_q : dir_q == 2'd2 ? ~|col_q : ~|row_q;
    goal = &{row_q, col_q};
    // Backtracking steps against the direction that was pushed on the way in
    br   = bus.stk_top == 2'd1 ? row_q - 4'd1 : bus.stk_top == 2'd3 ? row_q + 4'd1 : row_q;
    bc   = bus.stk_top == 2'd0 ? col_q - 4'd1 : bus.stk_top == 2'd2 ? col_q + 4'd1 : col_q;
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    bus.mem_addr = addr_q;
    bus.mem_wr   = 1'b0;
    bus.stk_push = 1'b0;
    bus.stk_dir  = 2'd0;
    bus.stk_pop  = 1'b0;
    bus.move     = 1'b0;
    bus.done     = 1'b0;
    bus.fail     = 1'b0;
    case (state_q)
      IDLE: state_d = bus.start ? INIT : IDLE;
      INIT: if (act) begin
        bus.mem_wr = 1'b1;
        state_d    = PROBE;
      end
      PROBE: if (goal) begin
        if (act) state_d = DONE;
      end else if (oob) begin
        if (act) state_d = NEXTDIR;
      end else begin
        bus.mem_addr = {nr, nc};
        if (act) begin
          addr_d  = {nr, nc};
          state_d = WAIT;
        end
      end
      WAIT: if (act) state_d = bus.mem_rd_data ? NEXTDIR : ADV;
      ADV: if (act) begin
        bus.stk_push = 1'b1;
        bus.stk_dir  = dir_q;
        bus.mem_wr   = 1'b1;
        bus.move     = 1'b1;
        row_d        = nr;
        col_d        = nc;
        dir_d        = 2'd0;
        state_d      = PROBE;
      end
      NEXTDIR: if (act) begin
        dir_d   = dir_q + 2'd1;
        state_d = dir_q == 2'd3 ? BACK : PROBE;
      end
      BACK: if (act) begin
        if (bus.stk_empty) state_d = FAIL;
        else begin
          bus.stk_pop = 1'b1;
          bus.move    = 1'b1;
          row_d       = br;
          col_d       = bc;
          dir_d       = bus.stk_top + 2'd1;
          state_d     = bus.stk_top == 2'd3 ? BACK : PROBE;
        end
      end
      DONE, FAIL: begin
        bus.done = state_q == DONE;
        bus.fail = state_q == FAIL;
        if (bus.start) begin
          state_d = INIT;
          row_d   = 4'd0;
          col_d   = 4'd0;
          dir_d   = 2'd0;
          addr_d  = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    bus.cur_row = row_q;
    bus.cur_col = col_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      dir_q   <= 2'd0;
      addr_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: doc/maze_solver_ctrl.md
MAZE_SOLVER_CTRL -- requirements
Module: maze_solver_ctrl

Interface
REQ-001 clk  input  1  Single system clock; all state updates on rising edge.
REQ-002 rst  input  1  Reset, synchronous, active-high.
REQ-003 start  input  1  Single-cycle pulse; begins a solve from cell (0,0).
REQ-004 run  input  1  Step enable; 0 pauses FSM in any solving state.
REQ-005 mem_addr  output  8  Maze cell address {row[3:0],col[3:0]}.
REQ-006 mem_wr  output  1  Write-enable; writes 1 (visited) to mem_addr.
REQ-007 mem_rd_data  input  1  Cell bit at mem_addr from previous cycle; 1 = wall or visited.
REQ-008 stk_push  output  1  Push stk_dir onto external direction stack.
REQ-009 stk_dir  output  2  Direction pushed: 0 right(col+1), 1 down(row+1), 2 left, 3 up.
REQ-010 stk_pop  output  1  Pop top entry at the rising edge where asserted.
REQ-011 stk_top  input  2  Current top-of-stack direction, combinational.
REQ-012 stk_empty  input  1  Stack holds no entries.
REQ-013 cur_row, cur_col  output  4 each  Current rat position.
REQ-014 move  output  1  One-cycle pulse for each position change (advance or backtrack).
REQ-015 done  output  1  Level; rat reached (15,15).
REQ-016 fail  output  1  Level; no path exists.

Function
REQ-017 States: IDLE, INIT, PROBE, WAIT, ADV, NEXTDIR, BACK, DONE, FAIL; one-hot or binary encoding.
REQ-018 IDLE: outputs low; start=1 -> INIT; otherwise stay.
REQ-019 INIT: pos=(0,0), dir=0, mem_wr=1 at addr 0x00 -> PROBE.
REQ-020 PROBE: pos==(15,15) -> DONE; neighbour in dir outside 0..15 -> NEXTDIR; else mem_addr=neighbour -> WAIT.
REQ-021 WAIT: mem_addr held; mem_rd_data=1 -> NEXTDIR; mem_rd_data=0 -> ADV.
REQ-022 ADV: stk_push=1 with stk_dir=dir, pos=neighbour, mem_wr=1 at neighbour address, move=1, dir=0 -> PROBE.
REQ-023 NEXTDIR: dir<3 -> dir+1, PROBE; dir==3 -> BACK.
REQ-024 BACK: stk_empty=1 -> FAIL; else stk_pop=1, pos stepped opposite stk_top, move=1; stk_top==3 -> stay BACK; else dir=stk_top+1 -> PROBE.
REQ-025 Position arithmetic is 4-bit unsigned; wrap never occurs because boundary check in PROBE precedes every step.
REQ-026 DONE/FAIL: respective flag held at 1; start=1 -> INIT with flag cleared same edge.
REQ-027 run=0 in INIT..BACK: state, pos, dir frozen; mem_wr, stk_push, stk_pop, move forced 0; mem_addr held.
REQ-028 start while in INIT..BACK is ignored.
REQ-029 At most one of stk_push, stk_pop asserted per cycle; mem_wr never asserted without a position change except in INIT.
REQ-030 Memory read latency is exactly one cycle; controller never samples mem_rd_data outside WAIT.
REQ-031 Clearing visited marks between solves is outside this block.

Reset
REQ-032 rst=1 at any edge forces IDLE, pos=(0,0), dir=0, all outputs 0 on the following cycle, overriding start and run.
REQ-033 During rst cycle no push, pop, write, or move is issued, including mid-solve.

Verification
REQ-034 Empty maze (all 0), start, run=1 -> done=1 after 30 ADV steps along row 0 then col 15; 30 move pulses; cur=(15,15).
REQ-035 Cell (0,1) and (1,0) walls -> BACK from (0,0) with stk_empty -> fail=1, zero move pulses.
REQ-036 Dead-end at (0,3) with only (0,4) blocked below/right -> backtrack pops with stk_top=0, move pulses, cur_col decrements to 2, search continues to done.
REQ-037 run dropped 5 cycles mid-solve -> state, cur_row/cur_col, mem_addr unchanged; no strobes; resumes identically.
REQ-038 rst pulsed during ADV -> next cycle IDLE, all outputs 0, no stk_push that cycle; start then reruns from (0,0).
REQ-039 start pulsed while in PROBE -> ignored; start in DONE -> INIT, done=0 next cycle.
